// File: rtl/and_gate_pkg.sv
// Shared defaults and helpers for the and_gate block.
// The optional hit counter is enabled by defining AND_GATE_CNT_EN.
package and_gate_pkg;

  localparam int AND_GATE_DEF_WIDTH = 1;
  localparam int AND_GATE_DEF_CNT_W = 16;

  // Largest value representable in w bits (all ones), i.e. 2^w - 1.
  // Valid for 1 <= w <= 64; callers truncate to their own width.
  function automatic logic [63:0] sat_max(input int unsigned w);
    logic [63:0] one;
    one = 64'd1;
    if (w >= 64) begin
      sat_max = '1;
    end else begin
      sat_max = (one << w) - one;
    end
  endfunction

endpackage

// File: rtl/and_gate_if.sv
// Operand/result bundle for the and_gate block.
// The master side drives the operands; the slave side (the gate) returns
// the combinational result, its registered copy and the reduction flags.
interface and_gate_if #(
  parameter int WIDTH = and_gate_pkg::AND_GATE_DEF_WIDTH
);

  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             all_o;
  logic             any_o;

  modport master (
    output i0,
    output i1,
    input  out,
    input  out_q,
    input  all_o,
    input  any_o
  );

  modport slave (
    input  i0,
    input  i1,
    output out,
    output out_q,
    output all_o,
    output any_o
  );

endinterface

// File: rtl/and_gate_sat_cnt.sv
// Generic saturating up-counter: counts cycles with inc high, sticks at
// all-ones instead of wrapping, cleared by synchronous active-low reset.
module and_gate_sat_cnt
  import and_gate_pkg::*;
#(
  parameter int CNT_W = AND_GATE_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  // Count up while inc is high, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND of two operands with a zero-latency result, all/any
// reduction flags and a one-cycle registered copy of the result.
// Define AND_GATE_CNT_EN to add the saturating "all bits set" hit counter
// on port cnt; without it the counter and its port do not exist.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_GATE_DEF_WIDTH,
  parameter int CNT_W = AND_GATE_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AND_GATE_CNT_EN
  output logic [CNT_W-1:0] cnt,
`endif
  and_gate_if.slave        bus
);

  // Reject degenerate widths at elaboration time.
  if (WIDTH < 1 || CNT_W < 1 || CNT_W > 64) begin : g_bad_param
    $error("and_gate: WIDTH must be >= 1 and CNT_W in 1..64");
  end

  // Combinational path: no clock or reset involvement, so the result is
  // valid as soon as the operands settle. X/Z propagate per '&' rules.
  assign bus.out   = bus.i0 & bus.i1;
  assign bus.all_o = &bus.out;
  assign bus.any_o = |bus.out;

  // Registered copy of the result, cleared while rst_n is low.
  // NOTE: reset is sampled only on the clock edge (synchronous), and state
  // is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= bus.out;
    end
  end

`ifdef AND_GATE_CNT_EN
  // Counts cycles in which every result bit is set.
  and_gate_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.all_o),
    .cnt   (cnt)
  );
`endif

endmodule

// File: tb/tb_and_gate.sv
// Directed, table-driven bench for and_gate: a 1-bit and a 4-bit instance,
// plus the saturating counter sequence when AND_GATE_CNT_EN is defined.
module tb_and_gate;

  logic clk;
  logic clk_run;
  logic rst_n;

  int n_checks;
  int n_errors;

  and_gate_if #(.WIDTH(1)) if1 ();
  and_gate_if #(.WIDTH(4)) if4 ();

`ifdef AND_GATE_CNT_EN
  logic [1:0] cnt1;
  logic [1:0] cnt4;
`endif

  and_gate #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AND_GATE_CNT_EN
    .cnt   (cnt1),
`endif
    .bus   (if1)
  );

  and_gate #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AND_GATE_CNT_EN
    .cnt   (cnt4),
`endif
    .bus   (if4)
  );

  // Clock only toggles once clk_run is set, so the first checks run with
  // no clock activity at all.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       all;
    logic       any;
  } vec4_t;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } vec1_t;

  vec1_t v1 [4];
  vec4_t v4 [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_run  = 1'b0;

    v1[0] = '{1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b1, 1'b0};
    v1[2] = '{1'b1, 1'b0, 1'b0};
    v1[3] = '{1'b1, 1'b1, 1'b1};

    v4[0] = '{4'b1010, 4'b1001, 4'b1000, 1'b0, 1'b1};
    v4[1] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};
    v4[2] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0};
    v4[3] = '{4'b0101, 4'b1010, 4'b0000, 1'b0, 1'b0};
    v4[4] = '{4'b0111, 4'b1110, 4'b0110, 1'b0, 1'b1};
    v4[5] = '{4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b1};

    // Combinational path with no clock activity and reset held.
    rst_n  = 1'b0;
    if1.i0 = 1'b1;
    if1.i1 = 1'b1;
    if4.i0 = 4'b1010;
    if4.i1 = 4'b1001;
    #3;
    check("noclk_out1", 64'(if1.out), 64'd1);
    check("noclk_all1", 64'(if1.all_o), 64'd1);
    check("noclk_any1", 64'(if1.any_o), 64'd1);
    check("noclk_out4", 64'(if4.out), 64'h8);
    check("noclk_all4", 64'(if4.all_o), 64'd0);
    check("noclk_any4", 64'(if4.any_o), 64'd1);

    // Reset held for two edges: out_q stays 0 while out tracks inputs.
    clk_run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_outq1", 64'(if1.out_q), 64'd0);
      check("rst_outq4", 64'(if4.out_q), 64'd0);
      check("rst_out1", 64'(if1.out), 64'd1);
    end
    rst_n = 1'b1;
    tick();
    check("rel_outq1", 64'(if1.out_q), 64'd1);
    check("rel_outq4", 64'(if4.out_q), 64'h8);

    // 1-bit truth-table sweep, combinational then registered.
    for (int i = 0; i < 4; i++) begin
      if1.i0 = v1[i].a;
      if1.i1 = v1[i].b;
      #1;
      check($sformatf("w1_out[%0d]", i), 64'(if1.out), 64'(v1[i].y));
      check($sformatf("w1_all[%0d]", i), 64'(if1.all_o), 64'(v1[i].y));
      check($sformatf("w1_any[%0d]", i), 64'(if1.any_o), 64'(v1[i].y));
      tick();
      check($sformatf("w1_outq[%0d]", i), 64'(if1.out_q), 64'(v1[i].y));
    end

    // 4-bit vectors, including all-ones and all-zero results.
    for (int i = 0; i < 6; i++) begin
      if4.i0 = v4[i].a;
      if4.i1 = v4[i].b;
      #1;
      check($sformatf("w4_out[%0d]", i), 64'(if4.out), 64'(v4[i].y));
      check($sformatf("w4_all[%0d]", i), 64'(if4.all_o), 64'(v4[i].all));
      check($sformatf("w4_any[%0d]", i), 64'(if4.any_o), 64'(v4[i].any));
      check($sformatf("w4_outq_hold[%0d]", i), 64'(if4.out_q),
            (i == 0) ? 64'h8 : 64'(v4[i-1].y));
      tick();
      check($sformatf("w4_outq[%0d]", i), 64'(if4.out_q), 64'(v4[i].y));
    end

    // Mid-operation reset: out_q clears on the next edge only.
    if4.i0 = 4'b1111;
    if4.i1 = 4'b1111;
    tick();
    check("mid_outq_pre", 64'(if4.out_q), 64'hf);
    rst_n = 1'b0;
    #1;
    check("mid_outq_before_edge", 64'(if4.out_q), 64'hf);
    check("mid_out_comb", 64'(if4.out), 64'hf);
    check("mid_all_comb", 64'(if4.all_o), 64'd1);
    tick();
    check("mid_outq_cleared", 64'(if4.out_q), 64'd0);
    check("mid_out_still", 64'(if4.out), 64'hf);
    rst_n = 1'b1;
    tick();
    check("mid_outq_resume", 64'(if4.out_q), 64'hf);

    // X propagation through the AND: 0 dominates, 1 passes X.
    if1.i0 = 1'b0;
    if1.i1 = 1'bx;
    #1;
    check("x_and0", 64'(if1.out), 64'd0);
    if1.i0 = 1'b1;
    #1;
    check("x_and1", {63'd0, if1.out}, {63'd0, 1'bx});

`ifdef AND_GATE_CNT_EN
    // Saturating counter with CNT_W=2: 1,2,3,3,3 then reset to 0.
    if1.i0 = 1'b0;
    if1.i1 = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("cnt_rst", 64'(cnt1), 64'd0);
    rst_n = 1'b1;
    tick();
    check("cnt_idle", 64'(cnt1), 64'd0);
    if1.i0 = 1'b1;
    if1.i1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("cnt_seq[%0d]", i), 64'(cnt1),
            (i < 3) ? 64'(i + 1) : 64'd3);
    end
    rst_n = 1'b0;
    tick();
    check("cnt_rst_after", 64'(cnt1), 64'd0);
    rst_n = 1'b1;
    if1.i0 = 1'b0;
    tick();
    check("cnt_hold_zero", 64'(cnt1), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
